// File: rtl/vx_pe_reorder_switch_if.sv
// Bundle of the dispatch-side request stream, the per-PE request/response buses
// and the in-order result stream of vx_pe_reorder_switch.
interface vx_pe_reorder_switch_if #(
  parameter int PE_COUNT   = 3,
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 64,
  parameter int DEPTH      = 8
);
  localparam int SEL_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int TAG_W = $clog2(DEPTH);

  // Every stream here uses strict valid/ready: a transfer happens on a rising
  // clk edge where valid & ready are both 1; valid never waits on ready.
  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]              in_sel;
  logic                          in_ready;
  logic [PE_COUNT-1:0]           pe_req_valid;
  logic [PE_COUNT*DATA_WIDTH-1:0] pe_req_data;
  logic [PE_COUNT*TAG_W-1:0]     pe_req_tag;
  logic [PE_COUNT-1:0]           pe_req_ready;
  logic [PE_COUNT-1:0]           pe_rsp_valid;
  logic [PE_COUNT*RES_WIDTH-1:0] pe_rsp_data;
  logic [PE_COUNT*TAG_W-1:0]     pe_rsp_tag;
  logic [PE_COUNT-1:0]           pe_rsp_ready;
  logic                          out_valid;
  logic [RES_WIDTH-1:0]          out_data;
  logic [TAG_W-1:0]              out_tag;
  logic                          out_ready;
  logic                          sel_err;

  modport master (
    output in_valid, in_data, in_sel, pe_req_ready,
    output pe_rsp_valid, pe_rsp_data, pe_rsp_tag, out_ready,
    input  in_ready, pe_req_valid, pe_req_data, pe_req_tag,
    input  pe_rsp_ready, out_valid, out_data, out_tag, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, pe_req_ready,
    input  pe_rsp_valid, pe_rsp_data, pe_rsp_tag, out_ready,
    output in_ready, pe_req_valid, pe_req_data, pe_req_tag,
    output pe_rsp_ready, out_valid, out_data, out_tag, sel_err
  );
endinterface

// File: rtl/vx_pe_reorder_switch.sv
// Reorder switch: issues requests to PE_COUNT PEs with ROB tags and releases results in
// issue order. Define VX_PE_REORDER_PERF_EN to add the saturating perf counter outputs.
module vx_pe_reorder_switch #(
  parameter int PE_COUNT   = 3,
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 64,
  parameter int DEPTH      = 8,
  localparam int SEL_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_pe_reorder_switch_if.slave bus,
  output logic [TAG_W:0]       dbg_count,
  output logic [SEL_W-1:0]     dbg_rr_ptr
`ifdef VX_PE_REORDER_PERF_EN
  ,
  output logic [31:0]          perf_full_stalls,
  output logic [31:0]          perf_rsp_conflicts
`endif
);
  localparam logic [TAG_W:0]   DEPTH_C    = (TAG_W+1)'(DEPTH);
  localparam logic [SEL_W:0]   PE_COUNT_C = (SEL_W+1)'(PE_COUNT);
  localparam logic [SEL_W-1:0] LAST_PE    = SEL_W'(PE_COUNT-1);

  logic [TAG_W-1:0]     alloc_ptr;
  logic [TAG_W-1:0]     head_ptr;
  logic [TAG_W:0]       count;
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     done;
  logic [RES_WIDTH-1:0] data_q [DEPTH];
  logic [SEL_W-1:0]     rr_ptr;

  logic                 full;
  logic                 sel_ok;
  logic                 sel_ready;
  logic                 in_fire;
  logic                 out_fire;
  logic                 rsp_fire;
  logic                 rsp_ok;
  logic [PE_COUNT-1:0]  grant;
  logic [SEL_W-1:0]     grant_idx;
  logic [TAG_W-1:0]     rsp_tag;
  logic [RES_WIDTH-1:0] rsp_data;

  assign full   = (count == DEPTH_C);
  assign sel_ok = ({1'b0, bus.in_sel} < PE_COUNT_C);

  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < PE_COUNT; i++)
      if (bus.in_sel == SEL_W'(i)) sel_ready = bus.pe_req_ready[i];
  end

  // reset_n gates the combinational handshakes so nothing is offered while held in reset
  assign bus.in_ready = reset_n & ~full & sel_ok & sel_ready;
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    bus.pe_req_valid = '0;
    for (int i = 0; i < PE_COUNT; i++)
      bus.pe_req_valid[i] = reset_n & bus.in_valid & ~full & (bus.in_sel == SEL_W'(i));
  end

  assign bus.pe_req_data = {PE_COUNT{bus.in_data}};
  assign bus.pe_req_tag  = {PE_COUNT{alloc_ptr}};

  // Round-robin: first pass covers rr_ptr..PE_COUNT-1, second pass wraps to 0..rr_ptr-1
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    rsp_fire  = 1'b0;
    for (int i = 0; i < PE_COUNT; i++)
      if (!rsp_fire && bus.pe_rsp_valid[i] && (SEL_W'(i) >= rr_ptr)) begin
        rsp_fire  = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    for (int i = 0; i < PE_COUNT; i++)
      if (!rsp_fire && bus.pe_rsp_valid[i] && (SEL_W'(i) < rr_ptr)) begin
        rsp_fire  = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    if (!reset_n) begin
      grant    = '0;
      rsp_fire = 1'b0;
    end
  end

  assign bus.pe_rsp_ready = grant;

  always_comb begin
    rsp_tag  = '0;
    rsp_data = '0;
    for (int i = 0; i < PE_COUNT; i++)
      if (grant[i]) begin
        rsp_tag  = bus.pe_rsp_tag[i*TAG_W +: TAG_W];
        rsp_data = bus.pe_rsp_data[i*RES_WIDTH +: RES_WIDTH];
      end
  end

  // Stray or duplicate responses are still acknowledged so a PE can never wedge
  assign rsp_ok = busy[rsp_tag] & ~done[rsp_tag];

  assign bus.out_valid = busy[head_ptr] & done[head_ptr];
  assign bus.out_data  = data_q[head_ptr];
  assign bus.out_tag   = head_ptr;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr   <= '0;
      head_ptr    <= '0;
      count       <= '0;
      busy        <= '0;
      done        <= '0;
      rr_ptr      <= '0;
      bus.sel_err <= 1'b0;
    end else begin
      bus.sel_err <= bus.in_valid & ~sel_ok;
      if (in_fire) begin
        busy[alloc_ptr] <= 1'b1;
        done[alloc_ptr] <= 1'b0;
        alloc_ptr       <= alloc_ptr + 1'b1;
      end
      if (rsp_fire && rsp_ok) done[rsp_tag] <= 1'b1;
      if (out_fire) begin
        busy[head_ptr] <= 1'b0;
        done[head_ptr] <= 1'b0;
        head_ptr       <= head_ptr + 1'b1;
      end
      if (rsp_fire) rr_ptr <= (grant_idx == LAST_PE) ? '0 : grant_idx + 1'b1;
      case ({in_fire, out_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire && rsp_ok) data_q[rsp_tag] <= rsp_data;
  end

  rsp_tag_outstanding: assert property (@(posedge clk) disable iff (!reset_n) rsp_fire |-> rsp_ok)
    else $error("vx_pe_reorder_switch: dropped response for tag %0d (not outstanding)", rsp_tag);

  assign dbg_count  = count;
  assign dbg_rr_ptr = rr_ptr;

`ifdef VX_PE_REORDER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_full_stalls   <= '0;
      perf_rsp_conflicts <= '0;
    end else begin
      if (bus.in_valid && full && !(&perf_full_stalls))
        perf_full_stalls <= perf_full_stalls + 1'b1;
      if (($countones(bus.pe_rsp_valid) > 1) && !(&perf_rsp_conflicts))
        perf_rsp_conflicts <= perf_rsp_conflicts + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vx_pe_reorder_switch.sv
// Directed bench for vx_pe_reorder_switch (PE_COUNT=3, DEPTH=8): issue/tagging, in-order
// release of out-of-order responses, round-robin grants, full/wrap, bad select, reset flush.
module tb_vx_pe_reorder_switch;
  localparam int PE_COUNT = 3;
  localparam int DW       = 64;
  localparam int RW       = 64;
  localparam int DEPTH    = 8;

  logic       clk;
  logic       reset_n;
  logic [3:0] dbg_count;
  logic [1:0] dbg_rr_ptr;
`ifdef VX_PE_REORDER_PERF_EN
  logic [31:0] perf_full_stalls;
  logic [31:0] perf_rsp_conflicts;
`endif

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  vx_pe_reorder_switch_if #(.PE_COUNT(PE_COUNT), .DATA_WIDTH(DW), .RES_WIDTH(RW), .DEPTH(DEPTH)) bus ();

  vx_pe_reorder_switch #(.PE_COUNT(PE_COUNT), .DATA_WIDTH(DW), .RES_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .dbg_count  (dbg_count),
    .dbg_rr_ptr (dbg_rr_ptr)
`ifdef VX_PE_REORDER_PERF_EN
    ,
    .perf_full_stalls   (perf_full_stalls),
    .perf_rsp_conflicts (perf_rsp_conflicts)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic issue(input int sel, input logic [63:0] d, input logic [2:0] exp_tag);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel[1:0];
    bus.in_data  = d;
    #1;
    chk("issue_in_ready", bus.in_ready, 1);
    chk("issue_pe_req_valid", bus.pe_req_valid, 3'b001 << sel);
    chk("issue_tag", bus.pe_req_tag, {3{exp_tag}});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic rsp(input int pe, input logic [2:0] tag, input logic [63:0] d);
    bus.pe_rsp_valid[pe]          = 1'b1;
    bus.pe_rsp_tag[pe*3 +: 3]     = tag;
    bus.pe_rsp_data[pe*RW +: RW]  = d;
    #1;
    chk("rsp_grant", bus.pe_rsp_ready, 3'b001 << pe);
    tick();
    bus.pe_rsp_valid[pe] = 1'b0;
  endtask

  // scoreboard check of the in-order output
  task automatic chk_out(input logic [2:0] tag);
    logic [RW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : {RW{1'bx}};
    chk("out_valid", bus.out_valid, 1);
    chk("out_tag", bus.out_tag, tag);
    chk("out_data", bus.out_data, e);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_sel       = 2'd1;
    bus.in_data      = '0;
    bus.pe_req_ready = 3'b111;
    bus.pe_rsp_valid = 3'b111;
    bus.pe_rsp_data  = '0;
    bus.pe_rsp_tag   = '0;
    bus.out_ready    = 1'b1;
    #1;
    // held in reset: nothing offered in either direction
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pe_req_valid", bus.pe_req_valid, 0);
    chk("rst_pe_rsp_ready", bus.pe_rsp_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sel_err", bus.sel_err, 0);
    chk("rst_count", dbg_count, 0);
    bus.pe_rsp_valid = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    // first request after release goes to PE1 with tag 0, then tag 1
    chk("first_pe_req_valid", bus.pe_req_valid, 3'b010);
    chk("first_in_ready", bus.in_ready, 1);
    chk("first_tag", bus.pe_req_tag, {3{3'd0}});
    tick();
    chk("second_tag", bus.pe_req_tag, {3{3'd1}});
    chk("count_one", dbg_count, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("count_two", dbg_count, 2);

    // in-order drain from PE1; second response overlaps the first retire
    exp_q.push_back(64'h10);
    rsp(1, 3'd0, 64'h10);
    chk_out(3'd0);
    exp_q.push_back(64'h11);
    rsp(1, 3'd1, 64'h11);
    chk_out(3'd1);
    tick();
    chk("drain_out_valid", bus.out_valid, 0);
    chk("drain_count", dbg_count, 0);
    chk("rr_after_pe1", dbg_rr_ptr, 2);

    // invalid select
    bus.in_sel   = 2'd3;
    bus.in_valid = 1'b1;
    #1;
    chk("badsel_in_ready", bus.in_ready, 0);
    chk("badsel_pe_req_valid", bus.pe_req_valid, 0);
    chk("badsel_sel_err_pre", bus.sel_err, 0);
    tick();
    chk("badsel_sel_err", bus.sel_err, 1);
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    tick();
    chk("badsel_sel_err_clear", bus.sel_err, 0);
    chk("badsel_count", dbg_count, 0);

    // A->PE2 (tag2), B->PE0 (tag3); PE0 answers first
    issue(2, 64'hA, 3'd2);
    issue(0, 64'hB, 3'd3);
    rsp(0, 3'd3, 64'hBB);
    chk("ooo_hold0", bus.out_valid, 0);
    tick();
    chk("ooo_hold1", bus.out_valid, 0);
    tick();
    chk("ooo_hold2", bus.out_valid, 0);
    exp_q.push_back(64'hAA);
    exp_q.push_back(64'hBB);
    rsp(2, 3'd2, 64'hAA);
    chk_out(3'd2);
    tick();
    chk_out(3'd3);
    tick();
    chk("ooo_empty", bus.out_valid, 0);
    chk("rr_after_pe2", dbg_rr_ptr, 0);

    // all three PEs respond together, rr_ptr=0
    issue(0, 64'h0, 3'd4);
    issue(1, 64'h1, 3'd5);
    issue(2, 64'h2, 3'd6);
    exp_q.push_back(64'hC0);
    exp_q.push_back(64'hC1);
    exp_q.push_back(64'hC2);
    bus.pe_rsp_valid = 3'b111;
    bus.pe_rsp_tag   = {3'd6, 3'd5, 3'd4};
    bus.pe_rsp_data  = {64'hC2, 64'hC1, 64'hC0};
    #1;
    chk("rr_grant0", bus.pe_rsp_ready, 3'b001);
    tick();
    bus.pe_rsp_valid[0] = 1'b0;
    #1;
    chk("rr_grant1", bus.pe_rsp_ready, 3'b010);
    chk("rr_ptr1", dbg_rr_ptr, 1);
    chk_out(3'd4);
    tick();
    bus.pe_rsp_valid[1] = 1'b0;
    #1;
    chk("rr_grant2", bus.pe_rsp_ready, 3'b100);
    chk("rr_ptr2", dbg_rr_ptr, 2);
    chk_out(3'd5);
    tick();
    bus.pe_rsp_valid[2] = 1'b0;
    #1;
    chk("rr_grant_none", bus.pe_rsp_ready, 3'b000);
    chk("rr_ptr_wrap", dbg_rr_ptr, 0);
    chk_out(3'd6);
    tick();
    chk("rr_empty", bus.out_valid, 0);

    // fill all 8 entries with out_ready=0; tags wrap 7 -> 0
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] t;
      t = 3'(7 + k);
      issue(0, 64'(k), t);
    end
    chk("full_count", dbg_count, 8);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    #1;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_pe_req_valid", bus.pe_req_valid, 0);
    exp_q.push_back(64'hD7);
    rsp(0, 3'd7, 64'hD7);
    chk_out(3'd7);
    bus.out_ready = 1'b1;
    #1;
    chk("full_no_bypass", bus.in_ready, 0);
    tick();
    chk("full_after_retire_count", dbg_count, 7);
    chk("full_reopen", bus.in_ready, 1);
    chk("full_reopen_tag", bus.pe_req_tag, {3{3'd7}});
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("refill_count", dbg_count, 8);

    // head result ready, then reset mid-flight
    rsp(0, 3'd0, 64'hE0);
    chk("pre_reset_out_valid", bus.out_valid, 1);
    chk("pre_reset_out_data", bus.out_data, 64'hE0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_count", dbg_count, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    tick();
    reset_n = 1'b1;
    issue(1, 64'h77, 3'd0);
    chk("post_reset_count", dbg_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
